scan_line_buffer: RTL
=====================

SCAN_LINE_BUFFER -- requirements
Module: scan_line_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, log2 of words per bank (DEPTH = 2^ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 32, width of one packed sample word.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_sync  input  1  start-of-scan strobe; same strobe as the decimation and packing stages.
REQ-006 SHALL have port i_data  input  DATA_W  packed sample word from the packing stage.
REQ-007 SHALL have port i_vld  input  1  i_data valid, one word per high cycle.
REQ-008 SHALL have port i_line_len  input  ADDR_W+1  words per scan line; sampled at i_sync.
REQ-009 SHALL have port o_complite  output  1  one-cycle pulse: line capture finished; drives the decimator's complete input.
REQ-010 SHALL have port o_line_rdy  output  1  a full bank is available to read.
REQ-011 SHALL have port i_rd_en  input  1  reader requests the next word.
REQ-012 SHALL have port o_rd_data  output  DATA_W  read word.
REQ-013 SHALL have port o_rd_vld  output  1  o_rd_data valid.
REQ-014 SHALL have port o_rd_last  output  1  qualifies the final word of a line, with o_rd_vld.
REQ-015 SHALL have port o_drop_cnt  output  8  lines dropped because no bank was free; saturates at 255.

Function
REQ-016 SHALL hold two banks of DEPTH x DATA_W (ping-pong); a write bank pointer and a read bank pointer; per-bank full flag and stored length.
REQ-017 Write FSM SHALL have states W_IDLE, W_FILL, W_SKIP.
REQ-018 On i_sync, any state: latch len = i_line_len, clamped to DEPTH when 0 or > DEPTH; wr_cnt <= 0; go W_FILL if write bank not full, else W_SKIP.
REQ-019 i_sync during W_FILL SHALL abort the partial line and restart at address 0 of the same bank, with no o_complite.
REQ-020 In W_FILL each i_vld cycle SHALL write i_data to write bank address wr_cnt and increment wr_cnt.
REQ-021 On the write where wr_cnt+1 == len: set bank full, store len, toggle write bank, pulse o_complite the next cycle, go W_IDLE.
REQ-022 On entering W_SKIP: pulse o_complite the next cycle; increment o_drop_cnt (saturating); ignore i_vld until the next i_sync.
REQ-023 i_vld in W_IDLE or W_SKIP SHALL be discarded.
REQ-024 If i_sync and i_vld occur together, i_sync SHALL win and that word SHALL be discarded.
REQ-025 o_line_rdy SHALL equal the full flag of the read bank.
REQ-026 When o_line_rdy && i_rd_en: read address rd_cnt; o_rd_vld and o_rd_data appear one cycle later (registered RAM read); rd_cnt increments.
REQ-027 o_rd_last SHALL assert with the word at address stored_len-1.
REQ-028 When that last address is issued: clear the read bank's full flag, toggle the read bank, rd_cnt <= 0; o_line_rdy drops in the same cycle as the last word's o_rd_vld.
REQ-029 A bank freed by the reader and a bank filled by the writer in the same cycle SHALL both take effect.
REQ-030 i_rd_en while o_line_rdy is low SHALL be ignored, with o_rd_vld low the next cycle.

Reset
REQ-031 While rst_n is low, all of the following SHALL be 0:
- o_complite, o_line_rdy, o_rd_vld, o_rd_last, o_drop_cnt, o_rd_data
- both full flags, both bank pointers, wr_cnt, rd_cnt
- FSM in W_IDLE
REQ-032 Reset mid-line or mid-read SHALL discard all buffered lines; RAM contents need not be cleared.

Verification
REQ-033 Basic fill: i_line_len=4, i_sync, then words 0xA0..0xA3 with gaps -> o_complite pulses once 1 cycle after the 4th write; o_line_rdy=1.
REQ-034 Readout: i_rd_en held high after REQ-033 -> o_rd_data A0,A1,A2,A3 on 4 consecutive cycles starting 1 cycle after the first request; o_rd_last only with A3; o_line_rdy=0 afterwards.
REQ-035 Overflow: fill two lines of len 2 without reading, then a third i_sync -> no write, o_complite pulse, o_drop_cnt=1; reading yields lines 1 then 2, intact.
REQ-036 Abort: len 8, i_sync, 3 words, i_sync, 8 words 0x10..0x17 -> exactly one o_complite; readout is 0x10..0x17.
REQ-037 Clamp/collision: i_line_len=0 with ADDR_W=3 -> line completes after 8 words; i_sync together with i_vld -> that word is not stored.
REQ-038 Reset mid-read: assert rst_n low during readout -> all outputs 0; o_line_rdy stays 0 until a new line fills.

Source files
------------

// File: rtl/scan_line_buffer.sv
// Ping-pong line buffer between the packing stage and the line reader.
// The writer fills one bank while the reader drains the other; a line that finds no free bank is dropped.
module scan_line_buffer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sync,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_vld,
  input  logic [ADDR_W:0]   i_line_len,
  output logic              o_complite,
  output logic              o_line_rdy,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_vld,
  output logic              o_rd_last,
  output logic [7:0]        o_drop_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0] W_IDLE = 2'd0, W_FILL = 2'd1, W_SKIP = 2'd2;

  logic [DATA_W-1:0] mem [2*DEPTH];

  logic [1:0]             wst_q, wst_d;
  logic [ADDR_W:0]        wr_cnt_q, wr_cnt_d, len_q, len_d, rd_cnt_q, rd_cnt_d;
  logic                   wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]             full_q, full_d;
  logic [1:0][ADDR_W:0]   slen_q, slen_d;
  logic                   complite_q, complite_d, rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic [DATA_W-1:0]      rd_data_q, rd_data_d;
  logic [7:0]             drop_q, drop_d;
  logic                   wr_en, rd_fire;
  logic [ADDR_W:0]        sync_len;

  always_comb begin
    sync_len   = (i_line_len == '0 || i_line_len > DEPTH_L) ? DEPTH_L : i_line_len;
    wst_d      = wst_q;
    wr_cnt_d   = wr_cnt_q;
    len_d      = len_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rd_cnt_d   = rd_cnt_q;
    full_d     = full_q;
    slen_d     = slen_q;
    drop_d     = drop_q;
    complite_d = 1'b0;
    wr_en      = 1'b0;
    // Sync has priority over a coincident data word, which is dropped.
    if (i_sync) begin
      len_d    = sync_len;
      wr_cnt_d = '0;
      if (!full_q[wr_bank_q]) begin
        wst_d = W_FILL;
      end else begin
        wst_d      = W_SKIP;
        complite_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end else if (wst_q == W_FILL && i_vld) begin
      wr_en    = 1'b1;
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_d == len_q) begin
        full_d[wr_bank_q] = 1'b1;
        slen_d[wr_bank_q] = len_q;
        wr_bank_d         = ~wr_bank_q;
        complite_d        = 1'b1;
        wst_d             = W_IDLE;
      end
    end

    // Writer only sets a non-full bank and reader only clears a full one, so
    // both flag updates in one cycle always land on different banks.
    rd_fire   = full_q[rd_bank_q] && i_rd_en;
    rd_vld_d  = rd_fire;
    rd_last_d = 1'b0;
    rd_data_d = rd_data_q;
    if (rd_fire) begin
      rd_data_d = mem[{rd_bank_q, rd_cnt_q[ADDR_W-1:0]}];
      rd_cnt_d  = rd_cnt_q + 1'b1;
      if (rd_cnt_d == slen_q[rd_bank_q]) begin
        rd_last_d         = 1'b1;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_cnt_d          = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank_q, wr_cnt_q[ADDR_W-1:0]}] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wst_q      <= W_IDLE;
      wr_cnt_q   <= '0;
      len_q      <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      full_q     <= '0;
      slen_q     <= '0;
      drop_q     <= '0;
      complite_q <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wst_q      <= wst_d;
      wr_cnt_q   <= wr_cnt_d;
      len_q      <= len_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_cnt_q   <= rd_cnt_d;
      full_q     <= full_d;
      slen_q     <= slen_d;
      drop_q     <= drop_d;
      complite_q <= complite_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_complite = complite_q;
  assign o_line_rdy = full_q[rd_bank_q];
  assign o_rd_data  = rd_data_q;
  assign o_rd_vld   = rd_vld_q;
  assign o_rd_last  = rd_last_q;
  assign o_drop_cnt = drop_q;
endmodule
